// File: rtl/sc_mmio_ctrl_if.sv
// CPU data-bus / data-memory signal bundle seen by the MMIO controller.
interface sc_mmio_ctrl_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] dmem_rdata;
   logic [31:0] rdata;
   logic        dmem_we;

   modport master (output addr, wdata, we, dmem_rdata, input rdata, dmem_we);
   modport slave  (input addr, wdata, we, dmem_rdata, output rdata, dmem_we);
endinterface

// File: rtl/sc_mmio_ctrl.sv
// Memory-mapped I/O controller: decodes a 256-byte window, provides synchronised
// input channels with change-detect pending bits, output registers, and a
// maskable level interrupt. Accesses outside the window pass through to dmem.

// One input channel: two-flop synchroniser, previous-value register and the
// change-detect pending bit (set has priority over write-1-to-clear).
module sc_mmio_in_ch #(
   parameter int IN_W = 8
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic [IN_W-1:0] din,
   input  logic            clr,
   output logic [IN_W-1:0] s2,
   output logic            pend
);
   logic [IN_W-1:0] s1, prev;

   // Synchronise, remember last settled value, flag any change.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
         pend <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
         pend <= (s2 != prev) | (pend & ~clr);
      end
   end
endmodule

module sc_mmio_ctrl #(
   parameter int          NUM_IN  = 4,
   parameter int          IN_W    = 8,
   parameter int          NUM_OUT = 6,
   parameter int          OUT_W   = 7,
   parameter logic [31:0] IO_BASE = 32'h0000_C000
) (
   input  logic                     clock,
   input  logic                     resetn,
   sc_mmio_ctrl_if.slave            bus,
   input  logic [NUM_IN*IN_W-1:0]   io_in,
   output logic [NUM_OUT*OUT_W-1:0] io_out,
   output logic                     irq
);
   localparam logic [5:0] W_PEND = 6'd32;
   localparam logic [5:0] W_MASK = 6'd33;
   localparam logic [5:0] W_ID   = 6'd34;

   logic                           io_sel, io_wr;
   logic [5:0]                     w;
   logic [31:0]                    io_rdata;
   logic [NUM_IN-1:0][IN_W-1:0]    s2_v;
   logic [NUM_IN-1:0]              pending, mask, clr;
   logic [NUM_OUT-1:0][OUT_W-1:0]  out_r;
   logic                           unused;

   assign io_sel = (bus.addr[31:8] == IO_BASE[31:8]);
   assign w      = bus.addr[7:2];
   assign io_wr  = bus.we & io_sel;

   // Byte offset bits and the upper store-data bits have no meaning here.
   assign unused = &{1'b0, bus.addr[1:0], bus.wdata};

   assign bus.dmem_we = bus.we & ~io_sel;
   assign bus.rdata   = io_sel ? io_rdata : bus.dmem_rdata;

   assign clr    = (io_wr && w == W_PEND) ? bus.wdata[NUM_IN-1:0] : '0;
   assign io_out = out_r;
   assign irq    = |(pending & mask);

   genvar g;
   generate
      for (g = 0; g < NUM_IN; g++) begin : g_in
         sc_mmio_in_ch #(.IN_W(IN_W)) u_ch (
            .clock  (clock),
            .resetn (resetn),
            .din    (io_in[g*IN_W +: IN_W]),
            .clr    (clr[g]),
            .s2     (s2_v[g]),
            .pend   (pending[g])
         );
      end
   endgenerate

   // Output and mask registers; writes land only on populated indices.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_r <= '0;
         mask  <= '0;
      end else if (io_wr) begin
         for (int k = 0; k < NUM_OUT; k++)
            if (w == 6'(16 + k)) out_r[k] <= bus.wdata[OUT_W-1:0];
         if (w == W_MASK) mask <= bus.wdata[NUM_IN-1:0];
      end
   end

   // Same-cycle read mux over the register map; unmapped indices read zero.
   always_comb begin
      io_rdata = '0;
      for (int k = 0; k < NUM_IN; k++)
         if (w == 6'(k)) io_rdata = 32'(s2_v[k]);
      for (int k = 0; k < NUM_OUT; k++)
         if (w == 6'(16 + k)) io_rdata = 32'(out_r[k]);
      if (w == W_PEND) io_rdata = 32'(pending);
      if (w == W_MASK) io_rdata = 32'(mask);
      if (w == W_ID)   io_rdata = {16'(NUM_IN), 16'(NUM_OUT)};
   end
endmodule
